// File: rtl/fft_bfly_sched_if.sv
// Block-level bus of fft_bfly_sched: frame input controls, butterfly
// schedule outputs, delay-line tracker outputs and error status.
interface fft_bfly_sched_if #(
   parameter int unsigned DELAY_LENGTH = 16
);
   localparam int unsigned TW = $clog2(DELAY_LENGTH);

   logic          flush;
   logic          din_valid;
   logic          din_sop;
   logic          bf_sel;
   logic [TW-1:0] tw_idx;
   logic          dly_valid;
   logic          dly_sop;
   logic          frame_done;
   logic          err_gap;
   logic          err_sop;
   logic [7:0]    err_cnt;

   modport master (
      output flush, din_valid, din_sop,
      input  bf_sel, tw_idx, dly_valid, dly_sop, frame_done,
             err_gap, err_sop, err_cnt
   );

   modport slave (
      input  flush, din_valid, din_sop,
      output bf_sel, tw_idx, dly_valid, dly_sop, frame_done,
             err_gap, err_sop, err_cnt
   );
endinterface

// File: rtl/fft_bfly_sched.sv
// Radix-2 SDF butterfly scheduler: sequences fill/butterfly phases of a
// delay line, issues twiddle indices, tracks blocks through the delay line
// and flags framing errors.
// Optional feature: define FFT_SCHED_ERRCNT_EN for a saturating error counter.
module fft_bfly_sched #(
   parameter int unsigned DELAY_LENGTH     = 16,
   parameter int unsigned BLOCKS_PER_FRAME = 32
) (
   input logic              clk,
   input logic              rstn,
   fft_bfly_sched_if.slave  sched
);
   localparam int unsigned DL  = DELAY_LENGTH;
   localparam int unsigned BPF = BLOCKS_PER_FRAME;
   localparam int unsigned CW  = $clog2(BPF);
   localparam int unsigned TW  = $clog2(DL);

   if ((DL < 2) || ((BPF % (2 * DL)) != 0)) begin : g_cfg_err
      $error("fft_bfly_sched: BLOCKS_PER_FRAME must be a multiple of 2*DELAY_LENGTH, DELAY_LENGTH >= 2");
   end

   typedef enum logic [1:0] {IDLE, FILL, BFLY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   nxt;
   logic [TW-1:0] tw;
   logic          acc, blk0, abort, gap_ev, sop_ev;
   logic          done_q, done_d;
   logic          err_gap_q, err_gap_d;
   logic          err_sop_q, err_sop_d;
   logic [DL-1:0] val_q, val_d;
   logic [DL-1:0] b0_q, b0_d;

   // Next-state, block acceptance and error event decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nxt     = '0;
      tw      = '0;
      acc     = 1'b0;
      blk0    = 1'b0;
      abort   = 1'b0;
      gap_ev  = 1'b0;
      sop_ev  = 1'b0;
      done_d  = 1'b0;
      if (sched.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (sched.din_valid && sched.din_sop) begin
         acc  = 1'b1;
         blk0 = 1'b1;
         nxt  = (CW+1)'(1);
         if (state_q != IDLE) begin
            sop_ev = 1'b1;
            abort  = 1'b1;
         end
      end else if (state_q != IDLE) begin
         if (sched.din_valid) begin
            acc = 1'b1;
            nxt = {1'b0, cnt_q} + (CW+1)'(1);
            tw  = TW'(32'(cnt_q) % DL);
         end else begin
            gap_ev  = 1'b1;
            abort   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
         end
      end
      if (acc) begin
         if (nxt == (CW+1)'(BPF)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            cnt_d   = nxt[CW-1:0];
            state_d = ((32'(nxt) % (2 * DL)) >= DL) ? BFLY : FILL;
         end
      end
   end

   // Delay-line tracker shift; on abort the current frame occupies exactly
   // the newest cnt_q slots because a live frame accepts a block every cycle
   always_comb begin
      val_d = '0;
      b0_d  = '0;
      if (!sched.flush) begin
         val_d[0] = acc;
         b0_d[0]  = blk0;
         for (int unsigned i = 1; i < DL; i++) begin
            if (!(abort && ((i - 1) < 32'(cnt_q)))) begin
               val_d[i] = val_q[i-1];
               b0_d[i]  = b0_q[i-1];
            end
         end
      end
   end

   // Sticky error flags; only reset clears them
   always_comb begin
      err_gap_d = err_gap_q | gap_ev;
      err_sop_d = err_sop_q | sop_ev;
   end

   // State, counter, tracker and status registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_gap_q <= 1'b0;
         err_sop_q <= 1'b0;
         val_q     <= '0;
         b0_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         err_gap_q <= err_gap_d;
         err_sop_q <= err_sop_d;
         val_q     <= val_d;
         b0_q      <= b0_d;
      end
   end

   assign sched.bf_sel     = (state_q == BFLY);
   assign sched.tw_idx     = tw;
   assign sched.dly_valid  = val_q[DL-1];
   assign sched.dly_sop    = b0_q[DL-1];
   assign sched.frame_done = done_q;
   assign sched.err_gap    = err_gap_q;
   assign sched.err_sop    = err_sop_q;

`ifdef FFT_SCHED_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Count every cycle carrying an error event, saturating at 255
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((gap_ev || sop_ev) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Error counter register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign sched.err_cnt = err_cnt_q;
`else
   assign sched.err_cnt = '0;
`endif
endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched (DELAY_LENGTH=16, BLOCKS_PER_FRAME=64).
// Vector table built from a behavioural frame model; delay-line outputs
// checked against a scoreboard queue of expected arrivals.
module tb_fft_bfly_sched;
   localparam int DL  = 16;
   localparam int BPF = 64;
`ifdef FFT_SCHED_ERRCNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fft_bfly_sched_if #(.DELAY_LENGTH(DL)) bus ();

   fft_bfly_sched #(.DELAY_LENGTH(DL), .BLOCKS_PER_FRAME(BPF)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .sched (bus)
   );

   typedef struct {
      bit v, s, f;
      bit e_bf;
      int e_tw;
      bit tw_chk;
      bit e_done;
      bit acc, b0;
      bit ev_gap, ev_sop;
      int kill_fid;
      int fid;
   } vec_t;

   typedef struct {
      int due;
      bit b0;
      int fid;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // behavioural frame model used to build the table
   bit m_in, m_pend_done;
   int m_k, m_fid;
   // expected status
   bit x_gap, x_sop;
   int x_cnt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_in = 0; m_pend_done = 0; m_k = 0;
      x_gap = 0; x_sop = 0; x_cnt = 0;
      sbq.delete();
   endfunction

   function automatic void gen(bit v, bit s, bit f);
      vec_t r;
      r = '{default: 0};
      r.kill_fid = -1;
      r.v = v; r.s = s; r.f = f;
      r.e_bf = m_in && ((m_k % (2 * DL)) >= DL);
      r.e_done = m_pend_done;
      m_pend_done = 0;
      if (f) begin
         m_in = 0; m_k = 0;
      end else if (v && s) begin
         r.acc = 1; r.b0 = 1; r.e_tw = 0; r.tw_chk = 1;
         if (m_in) begin r.ev_sop = 1; r.kill_fid = m_fid; end
         m_fid++;
         r.fid = m_fid;
         m_in = 1; m_k = 1;
      end else if (m_in && v) begin
         r.acc = 1; r.e_tw = m_k % DL; r.tw_chk = 1; r.fid = m_fid;
         m_k++;
         if (m_k == BPF) begin m_in = 0; m_k = 0; m_pend_done = 1; end
      end else if (m_in) begin
         r.ev_gap = 1; r.kill_fid = m_fid;
         m_in = 0; m_k = 0;
      end else begin
         r.e_tw = 0; r.tw_chk = 1;
      end
      tbl.push_back(r);
   endfunction

   function automatic void gen_n(bit v, bit s, bit f, int n);
      for (int i = 0; i < n; i++) gen(v, s, f);
   endfunction

   task automatic apply(input vec_t r);
      sb_t keep[$];
      @(posedge clk);
      #1;
      bus.din_valid = r.v;
      bus.din_sop   = r.s;
      bus.flush     = r.f;
      @(negedge clk);
      chk("bf_sel", bus.bf_sel, r.e_bf);
      if (r.tw_chk) chk("tw_idx", bus.tw_idx, r.e_tw);
      chk("frame_done", bus.frame_done, r.e_done);
      chk("err_gap", bus.err_gap, x_gap);
      chk("err_sop", bus.err_sop, x_sop);
      chk("err_cnt", bus.err_cnt, x_cnt);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         chk("dly_valid", bus.dly_valid, 1);
         chk("dly_sop", bus.dly_sop, sbq[0].b0);
         void'(sbq.pop_front());
      end else begin
         chk("dly_valid", bus.dly_valid, 0);
         chk("dly_sop", bus.dly_sop, 0);
      end
      if (r.f) begin
         sbq.delete();
      end else if (r.kill_fid >= 0) begin
         foreach (sbq[j]) if (sbq[j].fid != r.kill_fid) keep.push_back(sbq[j]);
         sbq = keep;
      end
      if (r.acc) sbq.push_back('{cyc + DL, r.b0, r.fid});
      if (r.ev_gap) x_gap = 1;
      if (r.ev_sop) x_sop = 1;
      if (CNT_EN != 0 && (r.ev_gap || r.ev_sop) && x_cnt < 255) x_cnt++;
      cyc++;
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      tbl.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.flush = 0; bus.din_valid = 0; bus.din_sop = 0;
      rstn = 0;
      m_fid = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_bf_sel", bus.bf_sel, 0);
      chk("rst_tw_idx", bus.tw_idx, 0);
      chk("rst_dly_valid", bus.dly_valid, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_err_cnt", bus.err_cnt, 0);
      rstn = 1;

      // single frame, then drain
      gen(1, 1, 0); gen_n(1, 0, 0, BPF - 1); gen_n(0, 0, 0, 20);
      // two frames back-to-back
      gen(1, 1, 0); gen_n(1, 0, 0, BPF - 1);
      gen(1, 1, 0); gen_n(1, 0, 0, BPF - 1); gen_n(0, 0, 0, 20);
      // valid dropped at block 20
      gen(1, 1, 0); gen_n(1, 0, 0, 19); gen(0, 0, 0); gen_n(0, 0, 0, 20);
      // sop at block 40 restarts the frame
      gen(1, 1, 0); gen_n(1, 0, 0, 39); gen(1, 1, 0); gen_n(1, 0, 0, BPF - 1);
      gen_n(0, 0, 0, 20);
      // flush at block 10 coinciding with sop, then a normal frame
      gen(1, 1, 0); gen_n(1, 0, 0, 9); gen(1, 1, 1); gen_n(0, 0, 0, 2);
      gen(1, 1, 0); gen_n(1, 0, 0, BPF - 1);
      // flush coinciding with a gap, then drain
      gen(1, 1, 0); gen_n(1, 0, 0, 3); gen(0, 0, 1); gen_n(0, 0, 0, 20);
      run_table();

      // reset asserted mid-frame while in a butterfly phase
      gen(1, 1, 0); gen_n(1, 0, 0, 24);
      run_table();
      #2 rstn = 0;
      #1;
      chk("arst_bf_sel", bus.bf_sel, 0);
      chk("arst_tw_idx", bus.tw_idx, 0);
      chk("arst_dly_valid", bus.dly_valid, 0);
      chk("arst_dly_sop", bus.dly_sop, 0);
      chk("arst_frame_done", bus.frame_done, 0);
      chk("arst_err_gap", bus.err_gap, 0);
      chk("arst_err_sop", bus.err_sop, 0);
      chk("arst_err_cnt", bus.err_cnt, 0);
      bus.din_valid = 0; bus.din_sop = 0; bus.flush = 0;
      repeat (2) @(negedge clk);
      rstn = 1;
      model_reset();

      // quiet after reset, then three gap errors
      gen_n(0, 0, 0, 3);
      for (int e = 0; e < 3; e++) begin
         gen(1, 1, 0); gen_n(1, 0, 0, 3); gen(0, 0, 0);
      end
      gen_n(0, 0, 0, 20);
      run_table();
      chk("err_cnt_final", bus.err_cnt, (CNT_EN != 0) ? 3 : 0);
      chk("err_gap_final", bus.err_gap, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
